// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Parametrised APB master. Takes single read/write requests on a valid/ready
//   port and runs each one as an APB SETUP/ACCESS transfer to one of NUM_SLAVES
//   slaves, selected by the top SEL_W address bits. Supports PREADY wait
//   states and passes slave errors through. An address whose slave index is
//   out of range ends with a decode error. An ACCESS phase that stays stalled
//   for TIMEOUT cycles is aborted with an error (TIMEOUT = 0 disables this).
//   All outputs are registered.
//
// Ports
//   PCLK, PRESETn       clock (rising edge), asynchronous active-low reset
//   transfer/req_ready  request handshake; accepted on an edge with both high
//   READ_WRITE          1 = read, 0 = write
//   req_addr/req_wdata  request address / write data (sampled at accept only)
//   rsp_valid           one-cycle response strobe
//   rsp_rdata, PSLVERR  response data / error; held until the next response
//   PADDR..PWDATA       APB master signals
//   PRDATA_S/PREADY_S/PSLVERR_S  per-slave returns, slave k at slice k
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         transfer,
    output logic                         req_ready,
    input  logic                         READ_WRITE,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         PSLVERR,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]        PREADY_S,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S
);

    localparam int SEL_RAW = $clog2(NUM_SLAVES);
    localparam int SEL_W   = (SEL_RAW < 1) ? 1 : SEL_RAW;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
    // One extra bit so NUM_SLAVES itself is representable for the range check.
    localparam logic [SEL_W:0]   NUM_LIM = (SEL_W + 1)'(NUM_SLAVES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DECERR = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  pslverr_q,   pslverr_d;
    logic [ADDR_W-1:0]     paddr_q,     paddr_d;
    logic [NUM_SLAVES-1:0] psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]     pwdata_q,    pwdata_d;
    logic [SEL_W-1:0]      sel_q,       sel_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    logic [SEL_W-1:0]      req_idx_s;
    logic                  idx_ok_s;
    logic [NUM_SLAVES-1:0] psel_dec_s;
    logic                  sel_ready_s;
    logic                  sel_err_s;
    logic [DATA_W-1:0]     sel_rdata_s;

    assign req_idx_s = req_addr[ADDR_W-1 -: SEL_W];
    assign idx_ok_s  = ({1'b0, req_idx_s} < NUM_LIM);

    // Decode the request index into a one-hot select and mux the selected
    // slave's returns; unselected slaves contribute nothing.
    always_comb begin
        psel_dec_s  = '0;
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        sel_rdata_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            psel_dec_s[k] = (req_idx_s == SEL_W'(k));
            sel_ready_s   = sel_ready_s | ((sel_q == SEL_W'(k)) & PREADY_S[k]);
            sel_err_s     = sel_err_s   | ((sel_q == SEL_W'(k)) & PSLVERR_S[k]);
            sel_rdata_s   = sel_rdata_s |
                            ({DATA_W{sel_q == SEL_W'(k)}} & PRDATA_S[k*DATA_W +: DATA_W]);
        end
    end

    // Transfer FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        pslverr_d   = pslverr_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    paddr_d     = req_addr;
                    pwrite_d    = ~READ_WRITE;
                    pwdata_d    = READ_WRITE ? '0 : req_wdata;
                    sel_d       = req_idx_s;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    if (idx_ok_s) begin
                        psel_d  = psel_dec_s;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DECERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    rsp_valid_d = 1'b1;
                    pslverr_d   = sel_err_s;
                    rsp_rdata_d = (!pwrite_q && !sel_err_s) ? sel_rdata_s : '0;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TO_EN && ((cnt_q + CNT_W'(1)) == TO_LIM)) begin
                    // Slave stalled for TIMEOUT access cycles: abort with error.
                    rsp_valid_d = 1'b1;
                    pslverr_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DECERR: begin
                rsp_valid_d = 1'b1;
                pslverr_d   = 1'b1;
                rsp_rdata_d = '0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                psel_d      = '0;
                penable_d   = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            pslverr_q   <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            pslverr_q   <= pslverr_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PSLVERR   = pslverr_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule
